pause_fade_ctrl: RTL and testbench

- Parametrised successor to the arcade-core pause block. Sits between the core's RGB/audio outputs and arcade_video / AUDIO_L/R.
- Merges user, OSD and N system pause requests (hiscore nvram, etc.) into one pause_cpu.
- Dims video after a programmable idle time while paused.
- Ramps audio gain down/up smoothly instead of hard-muting.

---
 rtl/pause_pkg.sv | 15 +
 rtl/audio_gain_ramp.sv | 61 ++++++
 rtl/pause_fade_ctrl.sv | 152 +++++++++++++++
 tb/tb_pause_fade_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pause_pkg.sv
// Shared types and helpers for the pause / fade controller.
package pause_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_DIMMED = 2'd2
    } pause_state_e;

    // Bits needed to hold a prescaler counting 0..ticks-1 (at least 1).
    function automatic int presc_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/audio_gain_ramp.sv
// Smooth audio gain ramp: free-running fade divider steps a saturating gain
// up or down, and a two-stage multiply/shift applies it to the sample.
module audio_gain_ramp
    import pause_pkg::*;
#(
    parameter int AW        = 16,
    parameter int GAIN_BITS = 6,
    parameter int FADE_DIV  = 256
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 fade_down,
    input  logic signed [AW-1:0] audio_in,
    output logic signed [AW-1:0] audio_out
);

    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int PW = AW + GAIN_BITS + 1;
    localparam logic [FW-1:0]        FADE_LAST = FW'(FADE_DIV - 1);
    localparam logic [GAIN_BITS:0]   GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};

    logic [FW-1:0]        fade_cnt;
    logic [GAIN_BITS:0]   gain;
    logic signed [PW-1:0] audio_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q;

    // Gain is never negative, so it enters the signed multiply zero-extended.
    assign audio_ext = PW'(audio_in);
    assign gain_ext  = PW'({1'b0, gain});
    assign prod_d    = audio_ext * gain_ext;

    // Fade divider and saturating gain step on each divider wrap.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fade_cnt <= '0;
            gain     <= GAIN_FULL;
        end else if (fade_cnt == FADE_LAST) begin
            fade_cnt <= '0;
            if (fade_down && gain != '0)
                gain <= gain - 1'b1;
            else if (!fade_down && gain != GAIN_FULL)
                gain <= gain + 1'b1;
        end else begin
            fade_cnt <= fade_cnt + FW'(1);
        end
    end

    // Stage 1 registers the product, stage 2 rescales back to sample width.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prod_q    <= '0;
            audio_out <= '0;
        end else begin
            prod_q    <= prod_d;
            audio_out <= AW'(prod_q >>> GAIN_BITS);
        end
    end

endmodule

// File: rtl/pause_fade_ctrl.sv
// Pause merge, idle dimming and audio fade for the arcade core outputs.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_RUN    | core running, video and audio pass through
//   ST_PAUSED | core halted, idle seconds accumulating
//   ST_DIMMED | core halted, idle timeout reached, video at half level
module pause_fade_ctrl
    import pause_pkg::*;
#(
    parameter int RW            = 3,
    parameter int GW            = 3,
    parameter int BW            = 3,
    parameter int NREQ          = 2,
    parameter int TICKS_PER_SEC = 40000000,
    parameter int DIM_SECONDS   = 10,
    parameter int AW            = 16,
    parameter int GAIN_BITS     = 6,
    parameter int FADE_DIV      = 256
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  user_button,
    input  logic [NREQ-1:0]       pause_request,
    input  logic [1:0]            options,
    input  logic                  OSD_STATUS,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic [RW+GW+BW-1:0]   rgb_out,
    input  logic signed [AW-1:0]  audio_in,
    output logic signed [AW-1:0]  audio_out,
    output logic                  pause_cpu,
    output logic                  dim_active,
    output logic [1:0]            state
);

    localparam int PW = presc_width(TICKS_PER_SEC);
    localparam int SW = (DIM_SECONDS > 0) ? $clog2(DIM_SECONDS + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [SW-1:0] SEC_MAX    = SW'(DIM_SECONDS);

    pause_state_e  st_q, st_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] secs_q, secs_d;
    logic          btn_q, btn_d1, user_pause;
    logic          btn_rise, sys_req, pause_req_any, wake;

    assign btn_rise      = btn_q & ~btn_d1;
    assign sys_req       = (|pause_request) | (options[0] & OSD_STATUS);
    assign pause_req_any = user_pause | sys_req;
    // A press that leaves the core paused only restarts the idle timer.
    assign wake          = btn_rise & (~user_pause | sys_req);

    assign state      = st_q;
    assign pause_cpu  = (st_q != ST_RUN);
    assign dim_active = (st_q == ST_DIMMED);

    // Register the button, detect its rising edge and toggle the user pause.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            btn_q      <= 1'b0;
            btn_d1     <= 1'b0;
            user_pause <= 1'b0;
        end else begin
            btn_q  <= user_button;
            btn_d1 <= btn_q;
            if (btn_rise)
                user_pause <= ~user_pause;
        end
    end

    // State register and idle timers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= ST_RUN;
            presc_q <= '0;
            secs_q  <= '0;
        end else begin
            st_q    <= st_d;
            presc_q <= presc_d;
            secs_q  <= secs_d;
        end
    end

    // Next state and timer updates; unpause always takes priority.
    always_comb begin
        st_d    = st_q;
        presc_d = presc_q;
        secs_d  = secs_q;
        case (st_q)
            ST_RUN: begin
                if (pause_req_any) begin
                    st_d    = ST_PAUSED;
                    presc_d = '0;
                    secs_d  = '0;
                end
            end
            ST_PAUSED: begin
                if (!pause_req_any) begin
                    st_d = ST_RUN;
                end else if (wake) begin
                    presc_d = '0;
                    secs_d  = '0;
                end else if (options[1] && secs_q == SEC_MAX) begin
                    st_d = ST_DIMMED;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (secs_q != SEC_MAX)
                        secs_d = secs_q + SW'(1);
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_DIMMED: begin
                if (!pause_req_any) begin
                    st_d = ST_RUN;
                end else if (wake) begin
                    st_d    = ST_PAUSED;
                    presc_d = '0;
                    secs_d  = '0;
                end else if (!options[1]) begin
                    st_d = ST_PAUSED;
                end
            end
            default: st_d = ST_RUN;
        endcase
    end

    // Registered video, each channel halved while dimmed.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            rgb_out <= '0;
        else if (st_q == ST_DIMMED)
            rgb_out <= {r >> 1, g >> 1, b >> 1};
        else
            rgb_out <= {r, g, b};
    end

    audio_gain_ramp #(
        .AW        (AW),
        .GAIN_BITS (GAIN_BITS),
        .FADE_DIV  (FADE_DIV)
    ) u_gain (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .fade_down (pause_cpu),
        .audio_in  (audio_in),
        .audio_out (audio_out)
    );

endmodule

// File: tb/tb_pause_fade_ctrl.sv
// Directed bench for pause_fade_ctrl with scoreboard queues for video/audio.
module tb_pause_fade_ctrl;

    logic               clk_sys = 1'b0;
    logic               reset_n;
    logic               user_button;
    logic [1:0]         pause_request;
    logic [1:0]         options;
    logic               OSD_STATUS;
    logic [2:0]         r, g, b;
    logic [8:0]         rgb_out;
    logic signed [15:0] audio_in;
    logic signed [15:0] audio_out;
    logic               pause_cpu;
    logic               dim_active;
    logic [1:0]         state;

    int n_checks = 0;
    int n_errors = 0;
    int span;

    logic [8:0]         rgb_q[$];
    logic signed [15:0] aud_q[$];

    pause_fade_ctrl #(
        .RW(3), .GW(3), .BW(3), .NREQ(2),
        .TICKS_PER_SEC(10), .DIM_SECONDS(3),
        .AW(16), .GAIN_BITS(2), .FADE_DIV(4)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .user_button   (user_button),
        .pause_request (pause_request),
        .options       (options),
        .OSD_STATUS    (OSD_STATUS),
        .r             (r),
        .g             (g),
        .b             (b),
        .rgb_out       (rgb_out),
        .audio_in      (audio_in),
        .audio_out     (audio_out),
        .pause_cpu     (pause_cpu),
        .dim_active    (dim_active),
        .state         (state)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check_rgb(input string tag);
        if (rgb_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            check(tag, 32'(rgb_out), 32'(rgb_q.pop_front()));
        end
    endtask

    // Follows audio_out changes, compares each new value against the queue
    // and reports the cycle distance from first to last expected change.
    task automatic run_fade(input string tag, output int span_o);
        logic signed [15:0] last;
        int first_at;
        last     = audio_out;
        first_at = -1;
        span_o   = -1;
        for (int t = 0; t < 60 && aud_q.size() > 0; t++) begin
            @(negedge clk_sys);
            if (audio_out !== last) begin
                last = audio_out;
                if (first_at < 0) first_at = t;
                check(tag, 32'(audio_out), 32'(aud_q.pop_front()));
                if (aud_q.size() == 0) span_o = t - first_at;
            end
        end
        check({tag, "_complete"}, 32'(aud_q.size()), 32'd0);
        aud_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        user_button   = 1'b0;
        pause_request = 2'b00;
        options       = 2'b00;
        OSD_STATUS    = 1'b0;
        r = 3'b111; g = 3'b111; b = 3'b111;
        audio_in      = 16'sd1000;
        #1;
        check("reset_rgb",   32'(rgb_out),   32'd0);
        check("reset_audio", 32'(audio_out), 32'd0);
        check("reset_pause", 32'(pause_cpu), 32'd0);
        check("reset_state", 32'(state),     32'd0);
        check("reset_dim",   32'(dim_active), 32'd0);

        step(2);
        reset_n = 1'b1;
        rgb_q.push_back(9'h1FF);
        aud_q.push_back(16'sd1000);
        step(1);
        check_rgb("rgb_latency1");
        check("audio_not_yet", 32'(audio_out), 32'd0);
        step(1);
        check("audio_latency2", 32'(audio_out), 32'(aud_q.pop_front()));
        check("run_pause", 32'(pause_cpu), 32'd0);
        check("run_state", 32'(state), 32'd0);

        for (int i = 0; i < 4; i++) begin
            r = 3'($urandom_range(0, 7));
            g = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            rgb_q.push_back({r, g, b});
            step(1);
            check_rgb("rgb_run_pattern");
        end

        // Button press held 50 cycles: exactly one toggle.
        user_button = 1'b1;
        step(2);
        check("press_not_yet", 32'(pause_cpu), 32'd0);
        step(1);
        check("press_pause", 32'(pause_cpu), 32'd1);
        check("press_state", 32'(state), 32'd1);
        step(47);
        check("held_no_retoggle", 32'(pause_cpu), 32'd1);
        user_button = 1'b0;
        step(3);
        check("release_still_paused", 32'(pause_cpu), 32'd1);
        user_button = 1'b1;
        step(3);
        check("second_press_unpause", 32'(pause_cpu), 32'd0);
        check("second_press_state", 32'(state), 32'd0);
        user_button = 1'b0;
        step(2);

        // Dimming after 3 seconds of 10 ticks.
        options = 2'b10;
        r = 3'b111; g = 3'b111; b = 3'b111;
        user_button = 1'b1;
        step(3);
        check("dim_entry_paused", 32'(state), 32'd1);
        user_button = 1'b0;
        step(28);
        check("dim_pre_timeout", 32'(state), 32'd1);
        step(3);
        check("dim_state", 32'(state), 32'd2);
        check("dim_active", 32'(dim_active), 32'd1);
        rgb_q.push_back(9'b011011011);
        step(1);
        check_rgb("rgb_dim_white");
        r = 3'b110; g = 3'b011; b = 3'b101;
        rgb_q.push_back(9'b011001010);
        step(1);
        check_rgb("rgb_dim_pattern");

        // Dim disable drops back to PAUSED and stays there.
        options = 2'b00;
        r = 3'b111; g = 3'b111; b = 3'b111;
        step(1);
        check("undim_state", 32'(state), 32'd1);
        check("undim_active", 32'(dim_active), 32'd0);
        rgb_q.push_back(9'h1FF);
        step(1);
        check_rgb("rgb_undim");
        step(60);
        check("no_dim_when_disabled", 32'(state), 32'd1);
        user_button = 1'b1;
        step(3);
        check("unpause_after_nodim", 32'(state), 32'd0);
        user_button = 1'b0;
        step(2);

        // System request, dim, then a waking press.
        options       = 2'b10;
        pause_request = 2'b10;
        step(1);
        check("sysreq_paused", 32'(state), 32'd1);
        step(31);
        check("sysreq_dimmed", 32'(state), 32'd2);
        user_button = 1'b1;
        step(2);
        check("wake_state", 32'(state), 32'd1);
        check("wake_undim", 32'(dim_active), 32'd0);
        user_button = 1'b0;
        step(20);
        check("wake_counters_cleared", 32'(state), 32'd1);
        pause_request = 2'b00;
        step(3);
        check("user_pause_holds", 32'(pause_cpu), 32'd1);
        user_button = 1'b1;
        step(3);
        check("wake_then_unpause", 32'(pause_cpu), 32'd0);
        user_button = 1'b0;
        options = 2'b00;
        step(2);

        // OSD pause gated by options[0].
        OSD_STATUS = 1'b1;
        step(2);
        check("osd_ignored", 32'(state), 32'd0);
        options = 2'b01;
        step(1);
        check("osd_pause", 32'(state), 32'd1);
        OSD_STATUS = 1'b0;
        step(1);
        check("osd_release", 32'(state), 32'd0);
        options = 2'b00;

        // Audio fade down and up.
        reset_n = 1'b0;
        step(1);
        audio_in = -16'sd1000;
        reset_n  = 1'b1;
        step(4);
        check("fade_start", 32'(audio_out), 32'(-1000));
        aud_q.push_back(-16'sd750);
        aud_q.push_back(-16'sd500);
        aud_q.push_back(-16'sd250);
        aud_q.push_back(16'sd0);
        user_button = 1'b1;
        step(2);
        user_button = 1'b0;
        run_fade("fade_down", span);
        check("fade_down_span", 32'(span), 32'd12);
        step(4);
        check("fade_floor", 32'(audio_out), 32'd0);
        aud_q.push_back(-16'sd250);
        aud_q.push_back(-16'sd500);
        aud_q.push_back(-16'sd750);
        aud_q.push_back(-16'sd1000);
        user_button = 1'b1;
        step(2);
        user_button = 1'b0;
        run_fade("fade_up", span);
        check("fade_up_span", 32'(span), 32'd12);

        // Reset in the middle of a ramp.
        user_button = 1'b1;
        step(2);
        user_button = 1'b0;
        step(10);
        reset_n = 1'b0;
        #1;
        check("midramp_audio", 32'(audio_out), 32'd0);
        check("midramp_state", 32'(state), 32'd0);
        check("midramp_pause", 32'(pause_cpu), 32'd0);
        check("midramp_rgb",   32'(rgb_out), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        step(2);
        check("gain_full_after_reset", 32'(audio_out), 32'(-1000));
        step(6);
        check("no_residual_toggle", 32'(pause_cpu), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
